// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared widths and lane-ratio helpers for the FIFO write-side logic.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int FIFO_DATA_W = 128;
    localparam int FIFO_IN_W   = 32;
    localparam int FIFO_CNT_W  = 16;

    function automatic int ratio_of(input int data_w, input int in_w);
        return data_w / in_w;
    endfunction

    // A single-bit lane index still needs one flop when RATIO is 2.
    function automatic int lane_idx_w(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    function automatic bit ratio_ok(input int data_w, input int in_w);
        return (in_w > 0) && ((data_w % in_w) == 0) && ((data_w / in_w) >= 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_hold_stage.sv
// ============================================================================
// Module  : fifo_wr_hold_stage
// Purpose : One-word holding register feeding the FIFO write port; counts writes.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_hold_stage #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_full,
    output logic              o_hold_vld,
    output logic              o_wren,
    output logic [DATA_W-1:0] o_wrdata,
    output logic [CNT_W-1:0]  o_wr_cnt
);

    logic [DATA_W-1:0] r_hold;
    logic              r_hold_vld;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              w_wren;

    assign w_wren = r_hold_vld & ~i_full;

    // A load in the same cycle as a drain wins, so the stage stays full.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_hold     <= '0;
            r_hold_vld <= 1'b0;
            r_wr_cnt   <= '0;
        end else begin
            if (i_load) begin
                r_hold     <= i_data;
                r_hold_vld <= 1'b1;
            end else if (w_wren) begin
                r_hold_vld <= 1'b0;
            end
            if (w_wren) begin
                r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign o_hold_vld = r_hold_vld;
    assign o_wren     = w_wren;
    assign o_wrdata   = r_hold;
    assign o_wr_cnt   = r_wr_cnt;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_packer.sv
// ============================================================================
// Module  : fifo_wr_packer
// Purpose : Packs IN_W-bit lanes LSB-first into DATA_W-bit FIFO words.
//           Define FIFO_WR_PACKER_LAST_EN to add s_last partial-word flushing.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_packer
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int IN_W   = FIFO_IN_W,
    parameter int CNT_W  = FIFO_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [IN_W-1:0]   s_data,
`ifdef FIFO_WR_PACKER_LAST_EN
    input  logic              s_last,
`endif
    input  logic              i_full,
    output logic              o_wren,
    output logic [DATA_W-1:0] o_wrdata,
    output logic [CNT_W-1:0]  o_wr_cnt,
    output logic              o_busy
);

    localparam int c_RATIO  = ratio_of(DATA_W, IN_W);
    localparam int c_LANE_W = lane_idx_w(c_RATIO);

    generate
        if (!ratio_ok(DATA_W, IN_W)) begin : g_bad_ratio
            $error("fifo_wr_packer: DATA_W must be a multiple of IN_W with ratio >= 2");
        end
    endgenerate

    logic [DATA_W-1:0]   r_acc;
    logic [c_LANE_W-1:0] r_lane_cnt;
    logic [DATA_W-1:0]   w_merged;
    logic                w_last;
    logic                w_completing_lane;
    logic                w_accept;
    logic                w_complete;
    logic                w_hold_vld;

`ifdef FIFO_WR_PACKER_LAST_EN
    assign w_last = s_last;
`else
    assign w_last = 1'b0;
`endif

    assign w_completing_lane = (r_lane_cnt == c_LANE_W'(c_RATIO - 1)) | w_last;
    // A completing lane needs a free (or draining) hold stage; others always go.
    assign s_ready    = rstn & (~w_completing_lane | ~w_hold_vld | ~i_full);
    assign w_accept   = s_valid & s_ready;
    assign w_complete = w_accept & w_completing_lane;

    // Lanes above the current one are already zero in the accumulator.
    always_comb begin
        w_merged = r_acc;
        for (int k = 0; k < c_RATIO; k++) begin
            if (r_lane_cnt == c_LANE_W'(k)) begin
                w_merged[k*IN_W +: IN_W] = s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_acc      <= '0;
            r_lane_cnt <= '0;
        end else if (w_complete) begin
            r_acc      <= '0;
            r_lane_cnt <= '0;
        end else if (w_accept) begin
            r_acc      <= w_merged;
            r_lane_cnt <= r_lane_cnt + c_LANE_W'(1);
        end
    end

    fifo_wr_hold_stage #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_hold (
        .clk        (clk),
        .rstn       (rstn),
        .i_load     (w_complete),
        .i_data     (w_merged),
        .i_full     (i_full),
        .o_hold_vld (w_hold_vld),
        .o_wren     (o_wren),
        .o_wrdata   (o_wrdata),
        .o_wr_cnt   (o_wr_cnt)
    );

    assign o_busy = w_hold_vld | (r_lane_cnt != '0);

endmodule

`default_nettype wire
